// File: rtl/rgb_hue_sequencer.sv
// Colour-wheel sequencer feeding the three PWM duty inputs of the RGB LED driver.
// Each advance moves exactly one channel by one duty level; pacing comes from the prescaler tick.
module rgb_hue_sequencer #(
  parameter int DUTY_WIDTH = 2,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_tick,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [HOLD_WIDTH-1:0] hold_limit,
  output logic [DUTY_WIDTH-1:0] duty_r,
  output logic [DUTY_WIDTH-1:0] duty_g,
  output logic [DUTY_WIDTH-1:0] duty_b,
  output logic [2:0]            phase,
  output logic                  wrap
);

  typedef enum logic [2:0] {
    PH_RED     = 3'd0,
    PH_YELLOW  = 3'd1,
    PH_GREEN   = 3'd2,
    PH_CYAN    = 3'd3,
    PH_BLUE    = 3'd4,
    PH_MAGENTA = 3'd5
  } phase_t;

  localparam logic [DUTY_WIDTH-1:0] MAX      = '1;
  localparam logic [DUTY_WIDTH-1:0] RAMP_TOP = MAX - DUTY_WIDTH'(1);

  phase_t                phase_q, phase_d;
  logic [DUTY_WIDTH-1:0] ramp_q, ramp_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_RED;
      ramp_q  <= '0;
      hold_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ramp_q  <= ramp_d;
      hold_q  <= hold_d;
      wrap_q  <= wrap_d;
    end
  end

  // The >= compare keeps the counter bounded when hold_limit drops below it mid-count.
  always_comb begin
    phase_d = phase_q;
    ramp_d  = ramp_q;
    hold_d  = hold_q;
    wrap_d  = 1'b0;
    if (restart) begin
      phase_d = PH_RED;
      ramp_d  = '0;
      hold_d  = '0;
    end else if (step_tick && enable) begin
      if (hold_q >= hold_limit) begin
        hold_d = '0;
        if (ramp_q < RAMP_TOP) begin
          ramp_d = ramp_q + DUTY_WIDTH'(1);
        end else begin
          ramp_d = '0;
          if (phase_q == PH_MAGENTA) begin
            phase_d = PH_RED;
            wrap_d  = 1'b1;
          end else begin
            phase_d = phase_t'(phase_q + 3'd1);
          end
        end
      end else begin
        hold_d = hold_q + HOLD_WIDTH'(1);
      end
    end
  end

  // Ramp never reaches MAX, so MAX - ramp_q cannot underflow.
  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    case (phase_q)
      PH_RED: begin
        duty_r = MAX;
        duty_g = ramp_q;
      end
      PH_YELLOW: begin
        duty_r = MAX - ramp_q;
        duty_g = MAX;
      end
      PH_GREEN: begin
        duty_g = MAX;
        duty_b = ramp_q;
      end
      PH_CYAN: begin
        duty_g = MAX - ramp_q;
        duty_b = MAX;
      end
      PH_BLUE: begin
        duty_r = ramp_q;
        duty_b = MAX;
      end
      PH_MAGENTA: begin
        duty_r = MAX;
        duty_b = MAX - ramp_q;
      end
      default: begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
      end
    endcase
  end

  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule
